rmii_rx_deframer: RTL and testbench

- Receive front end for the L1 RMII PHY port, clocked by the 50 MHz reference.
- Samples CRS_DV/RXD[1:0] dibits, strips preamble/SFD and assembles LSB-first bytes.
- Checks FCS (CRC-32), length and dibit alignment, then emits a byte stream with last/error flags.
- Drives mac_rx_data/mac_rx_valid into the MAC wrapper directly downstream.

---
 rtl/rmii_rx_deframer.sv | 206 ++++++++++++++++++++
 tb/tb_rmii_rx_deframer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_deframer.sv
// rmii_rx_deframer: RMII receive front end for the 50 MHz reference clock domain.
// Registers CRS_DV/RXD once, strips preamble/SFD, assembles LSB-first bytes,
// checks CRC-32, length and dibit alignment, and emits a byte stream with
// last/error flags.
//
// Ports:
//   clk           50 MHz RMII reference clock
//   rst           synchronous reset, active-high
//   rmii_crs_dv   PHY CRS_DV
//   rmii_rxd      PHY RXD, bit 0 is the earlier bit
//   mac_rx_data   received byte
//   mac_rx_valid  one-cycle strobe per byte
//   mac_rx_last   final byte of a frame (qualified by valid)
//   mac_rx_err    frame error (qualified by valid && last)
//   frame_cnt     count of good frames, wraps
module rmii_rx_deframer #(
    parameter int MIN_PRE_DIBITS = 8,
    parameter int MIN_FRAME_LEN  = 64,
    parameter int MAX_FRAME_LEN  = 1522
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rmii_crs_dv,
    input  logic [1:0]  rmii_rxd,
    output logic [7:0]  mac_rx_data,
    output logic        mac_rx_valid,
    output logic        mac_rx_last,
    output logic        mac_rx_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FLUSH, DROP} state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic        crs_q, low_prev_q;
    logic [1:0]  rxd_q;
    logic [4:0]  pre_cnt_q, pre_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [5:0]  sreg_q, sreg_d;
    logic [7:0]  held_q, held_d;
    logic        have_held_q, have_held_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  byte_new;
    logic        end_det, frame_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            crs_q       <= 1'b0;
            rxd_q       <= '0;
            low_prev_q  <= 1'b0;
            pre_cnt_q   <= '0;
            idx_q       <= '0;
            sreg_q      <= '0;
            held_q      <= '0;
            have_held_q <= 1'b0;
            crc_q       <= '1;
            byte_cnt_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            crs_q       <= rmii_crs_dv;
            rxd_q       <= rmii_rxd;
            low_prev_q  <= ~crs_q;
            pre_cnt_q   <= pre_cnt_d;
            idx_q       <= idx_d;
            sreg_q      <= sreg_d;
            held_q      <= held_d;
            have_held_q <= have_held_d;
            crc_q       <= crc_d;
            byte_cnt_q  <= byte_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        idx_d       = idx_q;
        sreg_d      = sreg_q;
        held_d      = held_q;
        have_held_d = have_held_q;
        crc_d       = crc_q;
        byte_cnt_d  = byte_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        byte_new    = {rxd_q, sreg_q};
        end_det     = 1'b0;
        frame_bad   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (crs_q) begin
                    state_d   = PREAMBLE;
                    pre_cnt_d = '0;
                end
            end
            PREAMBLE: begin
                if (!crs_q) begin
                    if (low_prev_q) state_d = IDLE;
                end else begin
                    unique case (rxd_q)
                        2'b00: ;
                        2'b01: if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
                        2'b11: begin
                            if (pre_cnt_q >= 5'(MIN_PRE_DIBITS)) begin
                                state_d     = DATA;
                                idx_d       = '0;
                                crc_d       = '1;
                                byte_cnt_d  = '0;
                                have_held_d = 1'b0;
                            end else begin
                                state_d = DROP;
                            end
                        end
                        default: state_d = DROP;
                    endcase
                end
            end
            DATA: begin
                // A lone low sample mid-byte is carrier-loss toggling and still
                // carries data; low on a byte boundary or twice in a row ends the frame.
                end_det = !crs_q && ((idx_q == 2'd0) || low_prev_q);
                if (end_det) begin
                    state_d     = IDLE;
                    have_held_d = 1'b0;
                    if (have_held_q) begin
                        frame_bad = (crc_q != CRC_RESIDUE) || (idx_q != 2'd0) ||
                                    (byte_cnt_q < 16'(MIN_FRAME_LEN));
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        data_d  = held_q;
                        err_d   = frame_bad;
                        if (!frame_bad) frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                    unique case (idx_q)
                        2'd0: sreg_d[1:0] = rxd_q;
                        2'd1: sreg_d[3:2] = rxd_q;
                        2'd2: sreg_d[5:4] = rxd_q;
                        default: begin
                            // Each byte is held one slot so the final one can carry last.
                            crc_d       = crc_byte(crc_q, byte_new);
                            byte_cnt_d  = byte_cnt_q + 16'd1;
                            held_d      = byte_new;
                            have_held_d = 1'b1;
                            if (have_held_q) begin
                                valid_d = 1'b1;
                                data_d  = held_q;
                            end
                            if (byte_cnt_d == 16'(MAX_FRAME_LEN)) state_d = FLUSH;
                        end
                    endcase
                end
            end
            FLUSH: begin
                valid_d     = 1'b1;
                last_d      = 1'b1;
                err_d       = 1'b1;
                data_d      = held_q;
                have_held_d = 1'b0;
                state_d     = DROP;
            end
            DROP: begin
                if (!crs_q && low_prev_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mac_rx_data  = data_q;
    assign mac_rx_valid = valid_q;
    assign mac_rx_last  = last_q;
    assign mac_rx_err   = err_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// tb_rmii_rx_deframer: directed bench for rmii_rx_deframer. Frames are built
// as byte queues with a locally computed FCS and driven as LSB-first dibits;
// every received strobe is recorded with its cycle number for checking.
module tb_rmii_rx_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rmii_crs_dv = 1'b0;
    logic [1:0]  rmii_rxd = 2'b00;
    logic [7:0]  mac_rx_data;
    logic        mac_rx_valid, mac_rx_last, mac_rx_err;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] s_data[$];
    logic       s_last[$];
    logic       s_err[$];
    int         s_cyc[$];

    logic [7:0] body[$];
    logic [7:0] exp_q[$];
    logic [7:0] wire_q[$];

    rmii_rx_deframer #(
        .MIN_PRE_DIBITS(8),
        .MIN_FRAME_LEN(64),
        .MAX_FRAME_LEN(1522)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rmii_crs_dv(rmii_crs_dv),
        .rmii_rxd(rmii_rxd),
        .mac_rx_data(mac_rx_data),
        .mac_rx_valid(mac_rx_valid),
        .mac_rx_last(mac_rx_last),
        .mac_rx_err(mac_rx_err),
        .frame_cnt(frame_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mac_rx_valid === 1'b1) begin
            s_data.push_back(mac_rx_data);
            s_last.push_back(mac_rx_last);
            s_err.push_back(mac_rx_err);
            s_cyc.push_back(cyc);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, got no completion, expected summary");
        $fatal(1);
    end

    function automatic logic [31:0] fcs_of(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[k]) begin
            for (int b = 0; b < 8; b++) begin
                c = (c >> 1) ^ (32'hEDB88320 & {32{c[0] ^ q[k][b]}});
            end
        end
        return ~c;
    endfunction

    task automatic build();
        logic [31:0] f;
        f = fcs_of(body);
        exp_q = body;
        for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
        wire_q = {};
        for (int k = 0; k < 7; k++) wire_q.push_back(8'h55);
        wire_q.push_back(8'hD5);
        foreach (exp_q[k]) wire_q.push_back(exp_q[k]);
    endtask

    task automatic make_body(input int len);
        body = {};
        for (int k = 0; k < len; k++) body.push_back(8'(k));
    endtask

    task automatic clear_rx();
        s_data = {}; s_last = {}; s_err = {}; s_cyc = {};
    endtask

    task automatic drive(input logic crs, input logic [1:0] d);
        rmii_crs_dv = crs;
        rmii_rxd    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00);
    endtask

    // Drives the first nbytes of wire_q; bytes tog_lo..tog_hi get CRS_DV low on dibit 2.
    task automatic send_wire(input int tog_lo, input int tog_hi, input int nbytes);
        logic [7:0] b;
        for (int k = 0; k < nbytes; k++) begin
            b = wire_q[k];
            for (int d = 0; d < 4; d++)
                drive(!(k >= tog_lo && k <= tog_hi && d == 2), b[2*d +: 2]);
        end
    endtask

    task automatic analyse(output int n, output int bad_data, output int bad_last,
                           output logic lerr, output int bad_gap, output int lgap);
        n = s_data.size();
        bad_data = 0; bad_last = 0; bad_gap = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= exp_q.size() || s_data[i] !== exp_q[i]) bad_data++;
            if (s_last[i] !== (i == n - 1)) bad_last++;
            if (i >= 1 && i <= n - 2 && (s_cyc[i] - s_cyc[i-1]) != 4) bad_gap++;
        end
        lerr = (n > 0) ? s_err[n-1] : 1'bx;
        lgap = (n > 1) ? s_cyc[n-1] - s_cyc[n-2] : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks++; if (mac_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", mac_rx_valid); end
        n_checks++; if (mac_rx_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", mac_rx_last); end
        n_checks++; if (mac_rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", mac_rx_err); end
        n_checks++; if (mac_rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", mac_rx_data); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_good_frame();
        int n, bd, bl, bg, lg; logic le;
        make_body(60); build(); clear_rx();
        send_wire(-1, -1, wire_q.size()); idle(6);
        analyse(n, bd, bl, le, bg, lg);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL good_count: got %0d expected 64", n); end
        n_checks++; if (bd !== 0) begin n_fail++; $display("FAIL good_data: got %0d bad bytes expected 0", bd); end
        n_checks++; if (bl !== 0) begin n_fail++; $display("FAIL good_last: got %0d misplaced last expected 0", bl); end
        n_checks++; if (le !== 1'b0) begin n_fail++; $display("FAIL good_err: got %b expected 0", le); end
        n_checks++; if (bg !== 0) begin n_fail++; $display("FAIL good_spacing: got %0d bad gaps expected 0", bg); end
        n_checks++; if (lg !== 1) begin n_fail++; $display("FAIL good_last_gap: got %0d expected 1", lg); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL good_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_bad_crc();
        int n, bd, bl, bg, lg; logic le;
        make_body(60); build(); clear_rx();
        exp_q[10]  = 8'hFF;
        wire_q[18] = 8'hFF;
        send_wire(-1, -1, wire_q.size()); idle(6);
        analyse(n, bd, bl, le, bg, lg);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL crc_count: got %0d expected 64", n); end
        n_checks++; if (bd !== 0) begin n_fail++; $display("FAIL crc_data: got %0d bad bytes expected 0", bd); end
        n_checks++; if (le !== 1'b1) begin n_fail++; $display("FAIL crc_err: got %b expected 1", le); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL crc_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_carrier_toggle();
        int n, bd, bl, bg, lg; logic le;
        make_body(60); build(); clear_rx();
        send_wire(8 + 40, 8 + 63, wire_q.size()); idle(6);
        analyse(n, bd, bl, le, bg, lg);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL toggle_count: got %0d expected 64", n); end
        n_checks++; if (bd !== 0) begin n_fail++; $display("FAIL toggle_data: got %0d bad bytes expected 0", bd); end
        n_checks++; if (bl !== 0) begin n_fail++; $display("FAIL toggle_last: got %0d misplaced last expected 0", bl); end
        n_checks++; if (le !== 1'b0) begin n_fail++; $display("FAIL toggle_err: got %b expected 0", le); end
        n_checks++; if (bg !== 0) begin n_fail++; $display("FAIL toggle_spacing: got %0d bad gaps expected 0", bg); end
        n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL toggle_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_runt();
        int n, bd, bl, bg, lg; logic le;
        make_body(16); build(); clear_rx();
        send_wire(-1, -1, wire_q.size()); idle(6);
        analyse(n, bd, bl, le, bg, lg);
        n_checks++; if (n !== 20) begin n_fail++; $display("FAIL runt_count: got %0d expected 20", n); end
        n_checks++; if (bd !== 0) begin n_fail++; $display("FAIL runt_data: got %0d bad bytes expected 0", bd); end
        n_checks++; if (le !== 1'b1) begin n_fail++; $display("FAIL runt_err: got %b expected 1", le); end
        n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL runt_frame_cnt: got %0d expected 2", frame_cnt); end
        // Full-length good frame followed by two dibits of a partial byte.
        make_body(60); build(); clear_rx();
        send_wire(-1, -1, wire_q.size());
        drive(1'b1, 2'b01); drive(1'b1, 2'b10);
        idle(6);
        analyse(n, bd, bl, le, bg, lg);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL partial_count: got %0d expected 64", n); end
        n_checks++; if (bd !== 0) begin n_fail++; $display("FAIL partial_data: got %0d bad bytes expected 0", bd); end
        n_checks++; if (le !== 1'b1) begin n_fail++; $display("FAIL partial_err: got %b expected 1", le); end
        n_checks++; if (lg !== 4) begin n_fail++; $display("FAIL partial_last_gap: got %0d expected 4", lg); end
        n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL partial_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_bad_preamble();
        int n, bd, bl, bg, lg; logic le;
        make_body(60); build(); clear_rx();
        wire_q[0] = 8'h55; wire_q[1] = 8'h57; wire_q[2] = 8'hD5;
        send_wire(-1, -1, 16); idle(2);
        n_checks++; if (s_data.size() !== 0) begin n_fail++; $display("FAIL preamble_drop: got %0d strobes expected 0", s_data.size()); end
        build(); clear_rx();
        send_wire(-1, -1, wire_q.size()); idle(6);
        analyse(n, bd, bl, le, bg, lg);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL recover_count: got %0d expected 64", n); end
        n_checks++; if (bd !== 0) begin n_fail++; $display("FAIL recover_data: got %0d bad bytes expected 0", bd); end
        n_checks++; if (le !== 1'b0) begin n_fail++; $display("FAIL recover_err: got %b expected 0", le); end
        n_checks++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL recover_frame_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_truncation();
        int n, bd, bl, bg, lg; logic le;
        make_body(1596); build(); clear_rx();
        send_wire(-1, -1, wire_q.size()); idle(6);
        analyse(n, bd, bl, le, bg, lg);
        n_checks++; if (n !== 1522) begin n_fail++; $display("FAIL trunc_count: got %0d expected 1522", n); end
        n_checks++; if (bd !== 0) begin n_fail++; $display("FAIL trunc_data: got %0d bad bytes expected 0", bd); end
        n_checks++; if (bl !== 0) begin n_fail++; $display("FAIL trunc_last: got %0d misplaced last expected 0", bl); end
        n_checks++; if (le !== 1'b1) begin n_fail++; $display("FAIL trunc_err: got %b expected 1", le); end
        n_checks++; if (bg !== 0) begin n_fail++; $display("FAIL trunc_spacing: got %0d bad gaps expected 0", bg); end
        n_checks++; if (lg !== 1) begin n_fail++; $display("FAIL trunc_last_gap: got %0d expected 1", lg); end
        n_checks++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL trunc_frame_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int n, bd, bl, bg, lg, nlast; logic le;
        make_body(60); build(); clear_rx();
        send_wire(-1, -1, 8 + 30);
        rst = 1'b1;
        drive(1'b1, 2'b01);
        n_checks++; if (mac_rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", mac_rx_valid); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_cnt: got %0d expected 0", frame_cnt); end
        rst = 1'b0;
        idle(6);
        nlast = 0;
        foreach (s_last[i]) if (s_last[i] === 1'b1) nlast++;
        n_checks++; if (nlast !== 0) begin n_fail++; $display("FAIL midrst_no_last: got %0d last strobes expected 0", nlast); end
        clear_rx();
        send_wire(-1, -1, wire_q.size()); idle(6);
        analyse(n, bd, bl, le, bg, lg);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL postrst_count: got %0d expected 64", n); end
        n_checks++; if (bd !== 0) begin n_fail++; $display("FAIL postrst_data: got %0d bad bytes expected 0", bd); end
        n_checks++; if (le !== 1'b0) begin n_fail++; $display("FAIL postrst_err: got %b expected 0", le); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL postrst_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_carrier_toggle();
        test_runt();
        test_bad_preamble();
        test_truncation();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
